// File: rtl/serial_subtractor4.sv
// Bit-serial 4-bit subtractor: DIFF = A - B, one bit per clock, LSB first, with a start/done handshake.
// Optional signed flags (OVF, NEG) are built when SUB_SIGNED_FLAGS_EN is defined.
module serial_subtractor4 (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       BUSY,
   output logic       DONE,
   output logic [3:0] DIFF,
   output logic       BOUT,
`ifdef SUB_SIGNED_FLAGS_EN
   output logic       OVF,
   output logic       NEG,
`endif
   output logic       STATE_DBG
);

   // Handshake: START is taken only while BUSY=0; DONE pulses once per completed subtraction.
   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic       br_q, br_d;
   logic [3:0] res_q, res_d;
   logic [3:0] diff_q, diff_d;
   logic       bout_q, bout_d;
   logic       done_q, done_d;
`ifdef SUB_SIGNED_FLAGS_EN
   logic       sa_q, sa_d;
   logic       sb_q, sb_d;
   logic       ovf_q, ovf_d;
   logic       neg_q, neg_d;
`endif

   logic       bit_a, bit_b, bit_d, br_nxt;
   logic [3:0] res_nxt;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         br_q    <= 1'b0;
         res_q   <= 4'd0;
         diff_q  <= 4'd0;
         bout_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         ovf_q   <= 1'b0;
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         done_q  <= done_d;
`ifdef SUB_SIGNED_FLAGS_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ovf_q   <= ovf_d;
         neg_q   <= neg_d;
`endif
      end
   end

   // Full-subtractor cell on the current LSBs; result bits enter at the MSB.
   always_comb begin
      bit_a   = a_q[0];
      bit_b   = b_q[0];
      bit_d   = bit_a ^ bit_b ^ br_q;
      br_nxt  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
      res_nxt = {bit_d, res_q[3:1]};
   end

   // Next-state
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      done_d  = 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
      sa_d    = sa_q;
      sb_d    = sb_q;
      ovf_d   = ovf_q;
      neg_d   = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_RUN;
               idx_d   = 2'd0;
               a_d     = A;
               b_d     = B;
               br_d    = 1'b0;
               res_d   = 4'd0;
`ifdef SUB_SIGNED_FLAGS_EN
               sa_d    = A[3];
               sb_d    = B[3];
`endif
            end
         end
         S_RUN: begin
            idx_d = idx_q + 2'd1;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_nxt;
            res_d = res_nxt;
            if (idx_q == 2'd3) begin
               state_d = S_IDLE;
               diff_d  = res_nxt;
               bout_d  = br_nxt;
               done_d  = 1'b1;
`ifdef SUB_SIGNED_FLAGS_EN
               ovf_d   = (sa_q != sb_q) & (res_nxt[3] != sa_q);
               neg_d   = res_nxt[3];
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      BUSY      = (state_q == S_RUN);
      DONE      = done_q;
      DIFF      = diff_q;
      BOUT      = bout_q;
      STATE_DBG = state_q;
`ifdef SUB_SIGNED_FLAGS_EN
      OVF       = ovf_q;
      NEG       = neg_q;
`endif
   end

endmodule

// File: tb/tb_serial_subtractor4.sv
// Scoreboarded bench for serial_subtractor4: directed cases, abort/ignore cases, then random operands.
// Builds with or without SUB_SIGNED_FLAGS_EN.
module tb_serial_subtractor4;

   logic       CLK = 1'b0;
   logic       RST, START;
   logic [3:0] A, B;
   logic       BUSY, DONE, BOUT, STATE_DBG;
   logic [3:0] DIFF;
   logic       ovf_a, neg_a;
`ifdef SUB_SIGNED_FLAGS_EN
   logic       OVF, NEG;
   assign ovf_a = OVF;
   assign neg_a = NEG;
`else
   assign ovf_a = 1'b0;
   assign neg_a = 1'b0;
`endif

   serial_subtractor4 dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF), .BOUT(BOUT),
`ifdef SUB_SIGNED_FLAGS_EN
      .OVF(OVF), .NEG(NEG),
`endif
      .STATE_DBG(STATE_DBG)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;
   logic [6:0] exp_q[$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain modular and signed arithmetic, packed {ovf, neg, bout, diff}.
   function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b);
      int sa, sb, sr;
      logic [3:0] d;
      logic bo, ov, ng;
      d  = 4'((int'(a) - int'(b) + 16) % 16);
      bo = (a < b);
      sa = (a > 4'd7) ? int'(a) - 16 : int'(a);
      sb = (b > 4'd7) ? int'(b) - 16 : int'(b);
      sr = sa - sb;
      ov = (sr > 7) || (sr < -8);
      ng = d[3];
`ifndef SUB_SIGNED_FLAGS_EN
      ov = 1'b0;
      ng = 1'b0;
`endif
      return {ov, ng, bo, d};
   endfunction

   // Monitor: pops the scoreboard on each DONE and watches hold/pulse/busy-length rules.
   initial begin : monitor
      logic [4:0] prev_out;
      logic       prev_rst;
      logic       prev_done;
      int         busy_len;
      logic [6:0] exp, act;
      prev_out  = 5'd0;
      prev_rst  = 1'b1;
      prev_done = 1'b0;
      busy_len  = 0;
      forever begin
         @(negedge CLK);
         act = {ovf_a, neg_a, BOUT, DIFF};
         if (DONE) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got result %0h with empty queue", act);
            end else begin
               exp = exp_q.pop_front();
               check("result", 32'(act), 32'(exp));
            end
            check("busy_len", busy_len, 4);
            check("done_pulse_prev", 32'(prev_done), 0);
         end else if (!prev_rst) begin
            check("hold_outputs", 32'({BOUT, DIFF}), 32'(prev_out));
         end
         busy_len  = BUSY ? busy_len + 1 : 0;
         prev_rst  = RST;
         prev_done = DONE;
         prev_out  = {BOUT, DIFF};
      end
   end

   task automatic issue(input logic [3:0] a, input logic [3:0] b);
      int g;
      g = 0;
      while (BUSY && g < 50) begin
         @(posedge CLK);
         #2;
         g++;
      end
      if (BUSY) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: BUSY stuck at %0b, required 0", BUSY);
      end
      START = 1'b1;
      A = a;
      B = b;
      exp_q.push_back(model(a, b));
      @(posedge CLK);
      #2;
      START = 1'b0;
      A = 4'($urandom);
      B = 4'($urandom);
      check("busy_after_accept", 32'(BUSY), 1);
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      do begin
         @(negedge CLK);
         g++;
      end while (!DONE && g < 20);
      if (!DONE) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: DONE=%0b after %0d cycles, required 1", DONE, g);
      end
   endtask

   initial begin : driver
      int d0, g;
      RST = 1'b1;
      START = 1'b0;
      A = 4'd0;
      B = 4'd0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_done", 32'(DONE), 0);
      check("rst_diff", 32'(DIFF), 0);
      check("rst_bout", 32'(BOUT), 0);
      check("rst_flags", 32'({ovf_a, neg_a}), 0);
      @(posedge CLK);
      #2;
      RST = 1'b0;

      issue(4'd9, 4'd5);
      wait_done();
      check("d9_5_diff", 32'(DIFF), 4);
      check("d9_5_bout", 32'(BOUT), 0);

      issue(4'd3, 4'd5);
      wait_done();
      check("d3_5_diff", 32'(DIFF), 14);
      check("d3_5_bout", 32'(BOUT), 1);
`ifdef SUB_SIGNED_FLAGS_EN
      check("d3_5_ovf", 32'(OVF), 0);
      check("d3_5_neg", 32'(NEG), 1);
`endif

      issue(4'd8, 4'd1);
      wait_done();
      check("d8_1_diff", 32'(DIFF), 7);
`ifdef SUB_SIGNED_FLAGS_EN
      check("d8_1_ovf", 32'(OVF), 1);
      check("d8_1_neg", 32'(NEG), 0);
`endif
      issue(4'd7, 4'd15);
      wait_done();
      check("d7_15_diff", 32'(DIFF), 8);
      check("d7_15_bout", 32'(BOUT), 1);
`ifdef SUB_SIGNED_FLAGS_EN
      check("d7_15_ovf", 32'(OVF), 1);
`endif

      // START pulsed mid-run must be ignored
      d0 = done_cnt;
      issue(4'd9, 4'd5);
      @(posedge CLK);
      #2;
      START = 1'b1;
      A = 4'd0;
      B = 4'd0;
      @(posedge CLK);
      #2;
      START = 1'b0;
      wait_done();
      check("ignored_start_diff", 32'(DIFF), 4);
      repeat (8) @(posedge CLK);
      #2;
      check("ignored_start_done_cnt", done_cnt - d0, 1);

      // Reset during the third RUN cycle aborts the operation
      issue(4'd12, 4'd3);
      @(posedge CLK);
      #2;
      RST = 1'b1;
      void'(exp_q.pop_back());
      @(posedge CLK);
      #2;
      RST = 1'b0;
      d0 = done_cnt;
      @(negedge CLK);
      check("abort_busy", 32'(BUSY), 0);
      check("abort_done", 32'(DONE), 0);
      check("abort_diff", 32'(DIFF), 0);
      check("abort_bout", 32'(BOUT), 0);
      repeat (8) @(posedge CLK);
      #2;
      check("abort_no_done", done_cnt - d0, 0);
      issue(4'd15, 4'd15);
      wait_done();
      check("d15_15_diff", 32'(DIFF), 0);
      check("d15_15_bout", 32'(BOUT), 0);

      // START held high: operands swapped on the DONE cycle
      @(posedge CLK);
      #2;
      START = 1'b1;
      A = 4'd6;
      B = 4'd2;
      exp_q.push_back(model(4'd6, 4'd2));
      @(posedge CLK);
      #2;
      g = 0;
      while (!DONE && g < 20) begin
         @(posedge CLK);
         #2;
         g++;
      end
      check("b2b_first_done", 32'(DONE), 1);
      check("b2b_first_diff", 32'(DIFF), 4);
      A = 4'd2;
      B = 4'd6;
      exp_q.push_back(model(4'd2, 4'd6));
      @(posedge CLK);
      #2;
      START = 1'b0;
      check("b2b_reaccept_busy", 32'(BUSY), 1);
      wait_done();
      check("b2b_second_diff", 32'(DIFF), 12);
      check("b2b_second_bout", 32'(BOUT), 1);
      check("b2b_spacing", last_done_cyc - prev_done_cyc, 5);

      // Random operands with random gaps
      repeat (40) begin
         issue(4'($urandom), 4'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            START = 1'b1;
            @(posedge CLK);
            #2;
            START = 1'b0;
         end
         repeat ($urandom_range(0, 6)) begin
            @(posedge CLK);
            #2;
         end
      end

      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge CLK);
         #2;
         g++;
      end
      check("queue_drained", exp_q.size(), 0);
      repeat (4) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor4.md
# serial_subtractor4

Bit-serial 4-bit subtractor, the inverse companion to the 4-bit ripple adder chain. It computes DIFF = A − B one bit per clock through a single full-subtractor cell and a registered borrow. It sits beside the adder in the lab datapath and trades combinational depth for a multi-cycle start/done handshake.

## Interface
Parameters:
- none. Width is fixed at 4 bits.

Ports:
- CLK  in  1  system clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only while BUSY=0.
- A  in  4  minuend, captured on the accepting edge.
- B  in  4  subtrahend, captured on the accepting edge.
- BUSY  out  1  high while a subtraction is in progress.
- DONE  out  1  one-cycle pulse; results valid.
- DIFF  out  4  (A − B) mod 16; held until the next completion.
- BOUT  out  1  final borrow; 1 iff A < B (unsigned).
- OVF  out  1  signed overflow; present only with SUB_SIGNED_FLAGS_EN.
- NEG  out  1  DIFF[3]; present only with SUB_SIGNED_FLAGS_EN.

Reset and clock are decided: one clock, CLK; reset RST is synchronous and active-high.

## Operation
- States:
  - IDLE: BUSY=0.
  - RUN: BUSY=1, with a 2-bit bit index i = 0..3.
- IDLE → RUN when START=1 on a rising edge:
  - a_sh ← A, b_sh ← B;
  - borrow register br ← 0;
  - i ← 0.
- In RUN, each edge processes bit i (LSB first):
  - d = a ^ b ^ br;
  - br' = (~a & b) | (~(a ^ b) & br);
  - d shifts into an internal result register;
  - a_sh and b_sh shift right.
- RUN → IDLE on the edge that processes i = 3. On that edge:
  - DIFF ← completed result;
  - BOUT ← br' of bit 3;
  - DONE ← 1.
- DONE clears on the next edge unless a new completion occurs on that edge. It cannot, because the minimum run is 4 cycles.
- START while BUSY=1 is ignored. There is no queueing, and A/B changes are ignored.
- START is accepted in the same cycle DONE=1, because BUSY=0 then.
- DIFF and BOUT never change mid-run. They update only on the completion edge.
- RST=1 forces the following on the next edge, taking priority over everything else:
  - state IDLE;
  - DIFF=0, BOUT=0, DONE=0, BUSY=0;
  - OVF=0, NEG=0;
  - br=0, i=0, all shift registers 0.
- RST mid-run aborts the operation. No DONE is produced.

## Timing
- Accepting edge k (START=1, BUSY=0): BUSY=1 from edge k.
- Edges k+1 .. k+4 process bits 0 .. 3.
- After edge k+4:
  - BUSY=0, DONE=1;
  - DIFF and BOUT (and OVF/NEG if enabled) valid.
- After edge k+5: DONE=0.
- Latency is 4 cycles from acceptance to DONE.
- Back-to-back: START held high gives one result every 5 cycles. The next acceptance occurs on edge k+5.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro SUB_SIGNED_FLAGS_EN.
- Defined:
  - OVF and NEG ports exist and are registered with DIFF on the completion edge;
  - OVF = (A[3] ≠ B[3]) & (DIFF[3] ≠ A[3]), using the captured operands;
  - NEG = DIFF[3];
  - both reset to 0.
- Undefined:
  - OVF and NEG ports are absent;
  - no captured sign bits are kept;
  - all other behaviour is identical.

## Test plan
- Reset, then A=9, B=5, START pulse: BUSY high 4 cycles, then DONE pulse; DIFF=4, BOUT=0.
- A=3, B=5: DIFF=14, BOUT=1. With the macro: OVF=0, NEG=1.
- A=8, B=1 with the macro: DIFF=7, BOUT=0, OVF=1, NEG=0. Also A=7, B=15: DIFF=8, BOUT=1, OVF=1.
- START re-pulsed with A=0, B=0 two cycles into the A=9, B=5 run: ignored; result still DIFF=4, with exactly one DONE.
- RST asserted during the 3rd RUN cycle: next edge BUSY=0, DONE=0, DIFF=0, BOUT=0. No DONE for the aborted op; a later A=15, B=15 gives DIFF=0, BOUT=0.
- START held high with operands (6,2) then (2,6), swapped on the DONE cycle: DONE at 5-cycle spacing with DIFF=4/BOUT=0, then DIFF=12/BOUT=1.
